// File: rtl/sd_apb_pkg.sv
// sd_apb_pkg: shared FSM state, error-cause encoding and default address map for the SD APB4 slave front-end
package sd_apb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_RANGE   = 3'd1,
    ERR_ALIGN   = 3'd2,
    ERR_PRIV    = 3'd3,
    ERR_SLAVE   = 3'd4,
    ERR_TIMEOUT = 3'd5
  } err_cause_t;
  localparam int unsigned DEF_REG_ADDR_MAX = 32'h005C;
  localparam int unsigned DEF_PROT_BASE    = 32'h0040;
endpackage

// File: rtl/sd_apb_watchdog.sv
// sd_apb_watchdog: counts reg-side wait cycles and pulses expired on the last allowed cycle
//   PCLK_i/PRESETn_i : clock, async active-low reset
//   clear_i          : restart the count from zero
//   run_i            : count this cycle
//   expired_o        : high during the TIMEOUT_CYCLES-th running cycle
module sd_apb_watchdog
  import sd_apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic PCLK_i,
  input  logic PRESETn_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);
  localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d     = clear_i ? '0 : run_i ? cnt_q + W'(1) : cnt_q;
    expired_o = run_i && (cnt_q == W'(TIMEOUT_CYCLES - 1));
  end
  always_ff @(posedge PCLK_i or negedge PRESETn_i)
    if (!PRESETn_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/sd_apb4_slave_if.sv
// sd_apb4_slave_if: APB4 slave front-end turning APB transfers into single-cycle register-file strobes
//   APB side  : PSEL_i/PENABLE_i/PWRITE_i/PADDR_i/PWDATA_i/PSTRB_i/PPROT_i in, PRDATA_o/PREADY_o/PSLVERR_o out
//   reg side  : reg_addr_o/reg_wdata_o/reg_wstrb_o/reg_read_o/reg_write_o out, reg_rdata_i/reg_ready_i/reg_error_i in
//   telemetry : err_cause_o (last error cause), err_cnt_o (saturating error-response count)
module sd_apb4_slave_if
  import sd_apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_MAX   = DEF_REG_ADDR_MAX,
  parameter int unsigned PROT_BASE      = DEF_PROT_BASE,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                      PCLK_i,
  input  logic                      PRESETn_i,
  input  logic                      PSEL_i,
  input  logic                      PENABLE_i,
  input  logic                      PWRITE_i,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR_i,
  input  logic [DATA_WIDTH-1:0]     PWDATA_i,
  input  logic [DATA_WIDTH/8-1:0]   PSTRB_i,
  input  logic [2:0]                PPROT_i,
  output logic [DATA_WIDTH-1:0]     PRDATA_o,
  output logic                      PREADY_o,
  output logic                      PSLVERR_o,
  output logic [APB_ADDR_WIDTH-1:0] reg_addr_o,
  output logic [DATA_WIDTH-1:0]     reg_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   reg_wstrb_o,
  output logic                      reg_read_o,
  output logic                      reg_write_o,
  input  logic [DATA_WIDTH-1:0]     reg_rdata_i,
  input  logic                      reg_ready_i,
  input  logic                      reg_error_i,
  output logic [2:0]                err_cause_o,
  output logic [7:0]                err_cnt_o
);
  localparam int unsigned SW = DATA_WIDTH / 8;
  localparam int unsigned AL = $clog2(SW);
  state_t                    state_q, state_d;
  err_cause_t                cause_q, cause_d, cause_dec, cause_new;
  logic                      err_q, err_d, write_q, write_d, abort_q, abort_d, abort_now;
  logic                      rd_q, rd_d, wr_q, wr_d, log_err, expired, run;
  logic [DATA_WIDTH-1:0]     prdata_q, prdata_d, wdata_q, wdata_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [SW-1:0]             wstrb_q, wstrb_d;
  logic [7:0]                cnt_q, cnt_d;
  logic                      unused_prot;
  assign unused_prot = ^PPROT_i[2:1];
  assign run = (state_q == S_REQ) || (state_q == S_WAIT);
  sd_apb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdog (
    .PCLK_i   (PCLK_i),
    .PRESETn_i(PRESETn_i),
    .clear_i  (!run),
    .run_i    (run),
    .expired_o(expired)
  );
  always_comb begin
    cause_dec = PADDR_i > APB_ADDR_WIDTH'(REG_ADDR_MAX) ? ERR_RANGE :
                PADDR_i[AL-1:0] != '0 ? ERR_ALIGN :
                (PWRITE_i && PADDR_i >= APB_ADDR_WIDTH'(PROT_BASE) && !PPROT_i[0]) ? ERR_PRIV : ERR_NONE;
    // PSEL dropping at any point of the reg-side phase abandons the APB response
    abort_now = abort_q || !PSEL_i;
    state_d   = state_q;
    err_d     = err_q;
    write_d   = write_q;
    abort_d   = abort_q;
    prdata_d  = prdata_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    log_err   = 1'b0;
    cause_new = ERR_NONE;
    case (state_q)
      S_IDLE:
        if (PSEL_i && !PENABLE_i) begin
          if (cause_dec != ERR_NONE) begin
            state_d   = S_RESP;
            err_d     = 1'b1;
            prdata_d  = '0;
            log_err   = 1'b1;
            cause_new = cause_dec;
          end else begin
            state_d = S_REQ;
            err_d   = 1'b0;
            write_d = PWRITE_i;
            abort_d = 1'b0;
            addr_d  = PADDR_i;
            wdata_d = PWDATA_i;
            wstrb_d = PWRITE_i ? PSTRB_i : '0;
            rd_d    = !PWRITE_i;
            wr_d    = PWRITE_i;
          end
        end
      S_REQ, S_WAIT: begin
        abort_d = abort_now;
        // a ready arriving in the same cycle as expiry still counts as in time
        if (reg_ready_i) begin
          state_d   = abort_now ? S_IDLE : S_RESP;
          err_d     = reg_error_i;
          prdata_d  = (write_q || reg_error_i) ? '0 : reg_rdata_i;
          log_err   = reg_error_i && !abort_now;
          cause_new = ERR_SLAVE;
        end else if (expired) begin
          state_d   = abort_now ? S_IDLE : S_RESP;
          err_d     = 1'b1;
          prdata_d  = '0;
          log_err   = !abort_now;
          cause_new = ERR_TIMEOUT;
        end else state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
    cause_d = log_err ? cause_new : cause_q;
    cnt_d   = log_err && cnt_q != 8'hFF ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge PCLK_i or negedge PRESETn_i)
    if (!PRESETn_i) begin
      state_q  <= S_IDLE;
      cause_q  <= ERR_NONE;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
      abort_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      prdata_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      err_q    <= err_d;
      write_q  <= write_d;
      abort_q  <= abort_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      prdata_q <= prdata_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      cnt_q    <= cnt_d;
    end
  assign PREADY_o    = state_q == S_RESP;
  assign PSLVERR_o   = (state_q == S_RESP) && err_q;
  assign PRDATA_o    = prdata_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign reg_wstrb_o = wstrb_q;
  assign reg_read_o  = rd_q;
  assign reg_write_o = wr_q;
  assign err_cause_o = cause_q;
  assign err_cnt_o   = cnt_q;
endmodule

// File: tb/tb_sd_apb4_slave_if.sv
// tb_sd_apb4_slave_if: directed APB transfers checked every cycle against a transfer-timeline model
module tb_sd_apb4_slave_if;
  localparam int TC = 64;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [15:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata, reg_wdata, rdata_i = '0;
  logic [3:0]  pstrb = '0, reg_wstrb;
  logic [2:0]  pprot = '0, err_cause;
  logic        pready, pslverr, reg_read, reg_write, ready_i = 1'b0, rerr_i = 1'b0;
  logic [15:0] reg_addr;
  logic [7:0]  err_cnt;
  int          vectors = 0, miscompares = 0;
  int          cnt_m = 0, cause_m = 0;
  bit          cmp_en = 1'b0;
  logic        exp_pready = 1'b0, exp_pslverr = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0, chk_prd = 1'b0;
  logic [31:0] exp_prd = '0, exp_wdata = '0;
  logic [15:0] exp_addr = '0;
  logic [3:0]  exp_wstrb = '0;

  always #5 clk = ~clk;

  sd_apb4_slave_if #(.TIMEOUT_CYCLES(TC)) dut (
    .PCLK_i(clk), .PRESETn_i(rstn), .PSEL_i(psel), .PENABLE_i(penable), .PWRITE_i(pwrite),
    .PADDR_i(paddr), .PWDATA_i(pwdata), .PSTRB_i(pstrb), .PPROT_i(pprot),
    .PRDATA_o(prdata), .PREADY_o(pready), .PSLVERR_o(pslverr),
    .reg_addr_o(reg_addr), .reg_wdata_o(reg_wdata), .reg_wstrb_o(reg_wstrb),
    .reg_read_o(reg_read), .reg_write_o(reg_write),
    .reg_rdata_i(rdata_i), .reg_ready_i(ready_i), .reg_error_i(rerr_i),
    .err_cause_o(err_cause), .err_cnt_o(err_cnt)
  );

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endtask

  function automatic int cause_of(input bit wr, input logic [15:0] a, input logic [2:0] pr);
    if (a > 16'h005C) return 1;
    if (a[1:0] != 2'b00) return 2;
    if (wr && a >= 16'h0040 && !pr[0]) return 3;
    return 0;
  endfunction

  always @(negedge clk)
    if (cmp_en) begin
      chk("PREADY", pready, exp_pready);
      chk("PSLVERR", pslverr, exp_pslverr);
      chk("reg_read", reg_read, exp_rd);
      chk("reg_write", reg_write, exp_wr);
      chk("err_cnt", err_cnt, cnt_m);
      chk("err_cause", err_cause, cause_m);
      if (chk_prd) chk("PRDATA", prdata, exp_prd);
      if (exp_rd || exp_wr) begin
        chk("reg_addr", reg_addr, exp_addr);
        chk("reg_wstrb", reg_wstrb, exp_wstrb);
      end
      if (exp_wr) chk("reg_wdata", reg_wdata, exp_wdata);
    end

  task automatic clr_exp();
    exp_pready = 1'b0; exp_pslverr = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; chk_prd = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      psel = 1'b0; penable = 1'b0; ready_i = 1'b0; rerr_i = 1'b0;
      clr_exp();
    end
  endtask

  // rdy: cycles after REQ until reg_ready_i (-1 never); drop: cycle PSEL falls (-1 never);
  // rst_at: cycle in which reset is pulsed (-1 never). Returns while the response cycle is current.
  task automatic xfer(input bit wr, input logic [15:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic [2:0] pr, input int rdy, input logic [31:0] rd, input bit re,
                      input int drop, input int rst_at);
    int  c  = cause_of(wr, a, pr);
    bit  intime = rdy >= 0 && rdy < TC;
    int  kr = c != 0 ? 1 : intime ? rdy + 2 : TC + 1;
    bit  to = c == 0 && !intime;
    bit  ab = c == 0 && drop >= 0 && drop < kr;
    for (int k = 0; k <= kr; k++) begin
      @(posedge clk); #1;
      psel    = !(drop >= 0 && k >= drop);
      penable = k > 0 && psel;
      pwrite  = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
      ready_i = c == 0 && rdy >= 0 && k == rdy + 1;
      rerr_i  = ready_i && re;
      rdata_i = rd;
      exp_rd    = c == 0 && k == 1 && !wr;
      exp_wr    = c == 0 && k == 1 && wr;
      exp_addr  = a;
      exp_wstrb = wr ? st : 4'h0;
      exp_wdata = wd;
      exp_pready  = k == kr && !ab;
      exp_pslverr = exp_pready && (c != 0 || to || re);
      chk_prd     = exp_pready && c == 0;
      exp_prd     = (to || wr || re) ? 32'h0 : rd;
      if (exp_pslverr) begin
        cause_m = c != 0 ? c : to ? 5 : 4;
        cnt_m   = cnt_m == 255 ? 255 : cnt_m + 1;
      end
      if (k == rst_at) begin
        rstn = 1'b0;
        clr_exp();
        cnt_m = 0; cause_m = 0;
        #1;
        chk("rst_PREADY", pready, 0);
        chk("rst_reg_read", reg_read, 0);
        chk("rst_PRDATA", prdata, 0);
        chk("rst_reg_addr", reg_addr, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_cause", err_cause, 0);
        @(posedge clk); #1;
        rstn = 1'b1; psel = 1'b0; penable = 1'b0; ready_i = 1'b0; rerr_i = 1'b0;
        return;
      end
    end
  endtask

  task automatic wr_t(input logic [15:0] a, input logic [31:0] d, input logic [3:0] st, input logic [2:0] pr, input int rdy);
    xfer(1'b1, a, d, st, pr, rdy, 32'h0, 1'b0, -1, -1);
  endtask

  task automatic rd_t(input logic [15:0] a, input int rdy, input logic [31:0] d, input bit re);
    xfer(1'b0, a, 32'h0, 4'h0, 3'b000, rdy, d, re, -1, -1);
  endtask

  initial begin
    @(posedge clk); #1;
    cmp_en = 1'b1;
    idle(2);
    rstn = 1'b1;
    chk("reset_PRDATA", prdata, 0);
    chk("reset_err_cnt", err_cnt, 0);
    idle(2);
    wr_t(16'h0010, 32'hDEADBEEF, 4'b0011, 3'b000, 0);
    rd_t(16'h0020, 3, 32'h12345678, 1'b0);
    chk("lit_read_data", prdata, 32'h12345678);
    rd_t(16'h0060, 0, 32'h0, 1'b0);
    chk("lit_range_cause", err_cause, 1);
    chk("lit_range_cnt", err_cnt, 1);
    chk("lit_range_slverr", pslverr, 1);
    wr_t(16'h0044, 32'hCAFEF00D, 4'b1111, 3'b000, 0);
    chk("lit_priv_cause", err_cause, 3);
    wr_t(16'h0044, 32'hCAFEF00D, 4'b1111, 3'b001, 1);
    chk("lit_priv_ok_slverr", pslverr, 0);
    rd_t(16'h0022, 0, 32'h0, 1'b0);
    rd_t(16'h0030, 0, 32'hFFFF0000, 1'b1);
    wr_t(16'h005C, 32'h01020304, 4'b1000, 3'b001, 0);
    rd_t(16'h005C, 2, 32'h00ABCDEF, 1'b0);
    wr_t(16'h003C, 32'h55AA55AA, 4'b0101, 3'b000, 0);
    xfer(1'b0, 16'h0008, 32'h0, 4'h0, 3'b000, 3, 32'h77777777, 1'b0, 2, -1);
    idle(1);
    rd_t(16'h0000, -1, 32'h0, 1'b0);
    chk("lit_timeout_cause", err_cause, 5);
    chk("lit_timeout_prdata", prdata, 0);
    chk("lit_timeout_slverr", pslverr, 1);
    rd_t(16'h000C, TC - 1, 32'h0BADCAFE, 1'b0);
    rd_t(16'h000C, TC, 32'h0BADCAFE, 1'b0);
    for (int i = 0; i < 300; i++) rd_t(16'h0060, 0, 32'h0, 1'b0);
    chk("lit_cnt_saturated", err_cnt, 255);
    xfer(1'b0, 16'h0004, 32'h0, 4'h0, 3'b000, -1, 32'h0, 1'b0, -1, 3);
    idle(1);
    rd_t(16'h0004, 1, 32'hA5A5A5A5, 1'b0);
    chk("lit_after_reset_data", prdata, 32'hA5A5A5A5);
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
